// File: rtl/hex_scan_capture_if.sv
// Scan-bus interface for hex_scan_capture: the scanned digit/nibble
// inputs and the rebuilt-frame outputs.
interface hex_scan_capture_if;
    logic [3:0]  seg_in;
    logic [2:0]  an_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        locked;

    modport master (
        output seg_in, an_in,
        input  data_out, data_valid, frame_err, locked
    );

    modport slave (
        input  seg_in, an_in,
        output data_out, data_valid, frame_err, locked
    );
endinterface

// File: rtl/hex_scan_capture.sv
// Receive side of the multiplexed hex scan bus: sync, glitch filter,
// digit-order check and 32-bit frame rebuild.
module hex_scan_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic clk100MHz,
    input logic reset,
    hex_scan_capture_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic {HUNT, ASSEMBLE} state_t;

    logic [6:0]    sync1, sync2, prev;
    logic [SW-1:0] scnt;
    logic          same, strobe;
    logic [2:0]    digit;
    logic [3:0]    nibble;

    state_t        state, state_n;
    logic [2:0]    expected, exp_n;
    logic [31:0]   shadow, shadow_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [31:0]   dout, dout_n;
    logic          dv, dv_n;
    logic          fe, fe_n;
    logic          lk, lk_n;

    assign same   = (sync2 == prev);
    assign strobe = same && (scnt == SW'(STABLE_CYCLES - 1));
    assign digit  = prev[6:4];
    assign nibble = prev[3:0];

    assign bus.data_out   = dout;
    assign bus.data_valid = dv;
    assign bus.frame_err  = fe;
    assign bus.locked     = lk;

    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            scnt  <= '0;
        end else begin
            sync1 <= {bus.an_in, bus.seg_in};
            sync2 <= sync1;
            prev  <= sync2;
            if (!same)
                scnt <= '0;
            else if (scnt != SW'(STABLE_CYCLES))
                scnt <= scnt + 1'b1;
        end
    end

    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            expected <= '0;
            shadow   <= '0;
            tcnt     <= '0;
            dout     <= '0;
            dv       <= 1'b0;
            fe       <= 1'b0;
            lk       <= 1'b0;
        end else begin
            state    <= state_n;
            expected <= exp_n;
            shadow   <= shadow_n;
            tcnt     <= tcnt_n;
            dout     <= dout_n;
            dv       <= dv_n;
            fe       <= fe_n;
            lk       <= lk_n;
        end
    end

    always_comb begin
        state_n  = state;
        exp_n    = expected;
        shadow_n = shadow;
        tcnt_n   = tcnt;
        dout_n   = dout;
        dv_n     = 1'b0;
        fe_n     = 1'b0;
        lk_n     = lk;
        unique case (state)
            HUNT: begin
                tcnt_n = '0;
                if (strobe && digit == 3'd0) begin
                    shadow_n[3:0] = nibble;
                    exp_n         = 3'd1;
                    state_n       = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                // tcnt counts the strobe cycle itself, so the timeout
                // lands TIMEOUT_CYCLES after the last accepted strobe
                if (strobe) begin
                    tcnt_n = TW'(1);
                    if (digit == expected) begin
                        if (digit == 3'd7) begin
                            dout_n  = {nibble, shadow[27:0]};
                            dv_n    = 1'b1;
                            lk_n    = 1'b1;
                            state_n = HUNT;
                        end else begin
                            shadow_n[{digit, 2'b00} +: 4] = nibble;
                            exp_n = expected + 3'd1;
                        end
                    end else begin
                        fe_n = 1'b1;
                        lk_n = 1'b0;
                        if (digit == 3'd0) begin
                            shadow_n[3:0] = nibble;
                            exp_n         = 3'd1;
                        end else begin
                            state_n = HUNT;
                        end
                    end
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    fe_n    = 1'b1;
                    lk_n    = 1'b0;
                    tcnt_n  = '0;
                    state_n = HUNT;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
        endcase
    end
endmodule
